// File: rtl/raster_pkg.sv
// raster_pkg
// Shared definitions for the triangle edge rasterizer:
//   state_t     - controller states (IDLE, SETUP, SCAN, DONE)
//   CULL_*      - cull_mode encodings
//   edge_width  - signed width of an edge-function value for a given coordinate width
package raster_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] CULL_NONE     = 2'd0;
    localparam logic [1:0] CULL_CW       = 2'd1;  // drop triangles with area < 0
    localparam logic [1:0] CULL_CCW      = 2'd2;  // drop triangles with area > 0
    localparam logic [1:0] CULL_NONE_ALT = 2'd3;  // behaves like CULL_NONE

    // A coordinate difference needs COORD_W+1 bits, a product of two such
    // differences 2*COORD_W+2, and the difference of two products one more.
    function automatic int edge_width(input int coord_w);
        return 2 * coord_w + 3;
    endfunction

endpackage

// File: rtl/edge_setup.sv
// edge_setup
// Combinational set-up for one directed edge a->b of a triangle.
// Ports:
//   xa, ya, xb, yb : edge end points
//   xc, yc         : the opposite vertex (edge value there is the triangle area)
//   ox, oy         : clip-rectangle origin where scanning starts
//   step_x         : increment of the edge value for x+1   ( yb-ya )
//   step_y         : increment of the edge value for y+1   (-(xb-xa))
//   e_origin       : edge value at (ox, oy)
//   e_far          : edge value at (xc, yc)
module edge_setup
    import raster_pkg::*;
#(
    parameter int COORD_W = 16
) (
    input  logic signed [COORD_W-1:0]             xa,
    input  logic signed [COORD_W-1:0]             ya,
    input  logic signed [COORD_W-1:0]             xb,
    input  logic signed [COORD_W-1:0]             yb,
    input  logic signed [COORD_W-1:0]             xc,
    input  logic signed [COORD_W-1:0]             yc,
    input  logic signed [COORD_W-1:0]             ox,
    input  logic signed [COORD_W-1:0]             oy,
    output logic signed [edge_width(COORD_W)-1:0] step_x,
    output logic signed [edge_width(COORD_W)-1:0] step_y,
    output logic signed [edge_width(COORD_W)-1:0] e_origin,
    output logic signed [edge_width(COORD_W)-1:0] e_far
);

    localparam int EW = edge_width(COORD_W);
    localparam int XW = EW - COORD_W;

    function automatic logic signed [EW-1:0] sext(input logic signed [COORD_W-1:0] v);
        return {{XW{v[COORD_W-1]}}, v};
    endfunction

    logic signed [EW-1:0] dx_s;
    logic signed [EW-1:0] dy_s;

    // Edge coefficients and the two evaluations, all at full edge width so no overflow
    always_comb begin
        dx_s     = sext(xb) - sext(xa);
        dy_s     = sext(yb) - sext(ya);
        step_x   = dy_s;
        step_y   = -dx_s;
        e_origin = (sext(ox) - sext(xa)) * dy_s - (sext(oy) - sext(ya)) * dx_s;
        e_far    = (sext(xc) - sext(xa)) * dy_s - (sext(yc) - sext(ya)) * dx_s;
    end

endmodule

// File: rtl/edge_rasterizer.sv
// edge_rasterizer
// Scan-converts one triangle per start request into a stream of pixels.
// Ports:
//   clk, rst_n          : clock and synchronous active-low reset
//   start, busy, done   : request / in-flight / one-cycle completion pulse
//   x0..y2              : triangle vertices (signed)
//   vp_xmin..vp_ymax    : inclusive viewport
//   color, cull_mode    : fill colour and back-face culling selection
//   pixel_valid/ready   : output handshake
//   pixel_x/y/color     : registered pixel payload
// The bounding box clipped to the viewport is walked in raster order, one
// candidate per cycle, with edge values updated by addition only.
module edge_rasterizer
    import raster_pkg::*;
#(
    parameter int COORD_W = 16,
    parameter int COLOR_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    input  logic signed [COORD_W-1:0] x0,
    input  logic signed [COORD_W-1:0] y0,
    input  logic signed [COORD_W-1:0] x1,
    input  logic signed [COORD_W-1:0] y1,
    input  logic signed [COORD_W-1:0] x2,
    input  logic signed [COORD_W-1:0] y2,
    input  logic signed [COORD_W-1:0] vp_xmin,
    input  logic signed [COORD_W-1:0] vp_ymin,
    input  logic signed [COORD_W-1:0] vp_xmax,
    input  logic signed [COORD_W-1:0] vp_ymax,
    input  logic        [COLOR_W-1:0] color,
    input  logic        [1:0]         cull_mode,
    output logic                      pixel_valid,
    input  logic                      pixel_ready,
    output logic signed [COORD_W-1:0] pixel_x,
    output logic signed [COORD_W-1:0] pixel_y,
    output logic        [COLOR_W-1:0] pixel_color
);

    localparam int EW = edge_width(COORD_W);

    function automatic logic signed [COORD_W-1:0] smin(input logic signed [COORD_W-1:0] a,
                                                        input logic signed [COORD_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic signed [COORD_W-1:0] smax(input logic signed [COORD_W-1:0] a,
                                                        input logic signed [COORD_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t state_r;
    state_t state_next_s;

    // Triangle captured at acceptance
    logic signed [COORD_W-1:0] vx_r [3];
    logic signed [COORD_W-1:0] vy_r [3];
    logic signed [COORD_W-1:0] vp_xmin_r, vp_ymin_r, vp_xmax_r, vp_ymax_r;
    logic        [COLOR_W-1:0] color_r;
    logic        [1:0]         cull_r;

    // Scan state
    logic signed [COORD_W-1:0] cx_r, cy_r;
    logic signed [COORD_W-1:0] cxmin_r, cxmax_r, cymax_r;
    logic signed [EW-1:0]      e_r   [3];
    logic signed [EW-1:0]      row_r [3];
    logic signed [EW-1:0]      sx_r  [3];
    logic signed [EW-1:0]      sy_r  [3];
    logic                      area_neg_r;
    logic                      cand_done_r;

    // Set-up results (valid while in SETUP)
    logic signed [COORD_W-1:0] clip_xmin_s, clip_xmax_s, clip_ymin_s, clip_ymax_s;
    logic signed [EW-1:0]      e_org_s [3];
    logic signed [EW-1:0]      stx_s   [3];
    logic signed [EW-1:0]      sty_s   [3];
    logic signed [EW-1:0]      far_s   [3];
    logic                      area_zero_s, area_neg_s, area_pos_s;
    logic                      culled_s, clip_empty_s, reject_s;

    // Scan helpers
    logic                      inside_s;
    logic                      advance_s;
    logic                      row_end_s;
    logic                      last_s;

    // Bounding box of the latched vertices intersected with the latched viewport
    always_comb begin
        clip_xmin_s  = smax(smin(smin(vx_r[0], vx_r[1]), vx_r[2]), vp_xmin_r);
        clip_xmax_s  = smin(smax(smax(vx_r[0], vx_r[1]), vx_r[2]), vp_xmax_r);
        clip_ymin_s  = smax(smin(smin(vy_r[0], vy_r[1]), vy_r[2]), vp_ymin_r);
        clip_ymax_s  = smin(smax(smax(vy_r[0], vy_r[1]), vy_r[2]), vp_ymax_r);
        clip_empty_s = (clip_xmin_s > clip_xmax_s) || (clip_ymin_s > clip_ymax_s);
    end

    // Edge i runs from vertex i to vertex i+1; its far vertex is i+2, so every
    // e_far equals the doubled signed area of the triangle.
    for (genvar i = 0; i < 3; i++) begin : g_edge
        localparam int IB = (i + 1) % 3;
        localparam int IC = (i + 2) % 3;
        edge_setup #(
            .COORD_W (COORD_W)
        ) u_edge_setup (
            .xa       (vx_r[i]),
            .ya       (vy_r[i]),
            .xb       (vx_r[IB]),
            .yb       (vy_r[IB]),
            .xc       (vx_r[IC]),
            .yc       (vy_r[IC]),
            .ox       (clip_xmin_s),
            .oy       (clip_ymin_s),
            .step_x   (stx_s[i]),
            .step_y   (sty_s[i]),
            .e_origin (e_org_s[i]),
            .e_far    (far_s[i])
        );
    end

    // Area classification and cull / reject decision. The three area copies
    // are the same quantity; all of them are checked for degeneracy.
    always_comb begin
        area_zero_s = (far_s[0] == '0) || (far_s[1] == '0) || (far_s[2] == '0);
        area_neg_s  = far_s[0][EW-1];
        area_pos_s  = !area_neg_s && !area_zero_s;
        case (cull_r)
            CULL_CW:       culled_s = area_neg_s;
            CULL_CCW:      culled_s = area_pos_s;
            CULL_NONE:     culled_s = 1'b0;
            CULL_NONE_ALT: culled_s = 1'b0;
            default:       culled_s = 1'b0;
        endcase
        reject_s = area_zero_s || clip_empty_s || culled_s;
    end

    // Candidate classification and scanner advance condition
    always_comb begin
        if (area_neg_r) begin
            inside_s = (e_r[0][EW-1] || (e_r[0] == '0)) &&
                       (e_r[1][EW-1] || (e_r[1] == '0)) &&
                       (e_r[2][EW-1] || (e_r[2] == '0));
        end else begin
            inside_s = !e_r[0][EW-1] && !e_r[1][EW-1] && !e_r[2][EW-1];
        end
        advance_s = !pixel_valid || pixel_ready;
        row_end_s = (cx_r == cxmax_r);
        last_s    = row_end_s && (cy_r == cymax_r);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; SCAN leaves once every candidate is evaluated and the
    // output register empties (or empties on this very edge).
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_SETUP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (reject_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cand_done_r && advance_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SCAN;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state register
    always_comb begin
        busy = 1'b1;
        done = 1'b0;
        case (state_r)
            ST_IDLE:  busy = 1'b0;
            ST_SETUP: done = 1'b0;
            ST_SCAN:  done = 1'b0;
            ST_DONE:  done = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    // Triangle capture, set-up registration and incremental scan walk
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                vx_r[i]  <= '0;
                vy_r[i]  <= '0;
                e_r[i]   <= '0;
                row_r[i] <= '0;
                sx_r[i]  <= '0;
                sy_r[i]  <= '0;
            end
            vp_xmin_r   <= '0;
            vp_ymin_r   <= '0;
            vp_xmax_r   <= '0;
            vp_ymax_r   <= '0;
            color_r     <= '0;
            cull_r      <= 2'd0;
            cx_r        <= '0;
            cy_r        <= '0;
            cxmin_r     <= '0;
            cxmax_r     <= '0;
            cymax_r     <= '0;
            area_neg_r  <= 1'b0;
            cand_done_r <= 1'b0;
        end else if (state_r == ST_IDLE && start) begin
            vx_r[0]   <= x0;
            vy_r[0]   <= y0;
            vx_r[1]   <= x1;
            vy_r[1]   <= y1;
            vx_r[2]   <= x2;
            vy_r[2]   <= y2;
            vp_xmin_r <= vp_xmin;
            vp_ymin_r <= vp_ymin;
            vp_xmax_r <= vp_xmax;
            vp_ymax_r <= vp_ymax;
            color_r   <= color;
            cull_r    <= cull_mode;
        end else if (state_r == ST_SETUP) begin
            for (int i = 0; i < 3; i++) begin
                e_r[i]   <= e_org_s[i];
                row_r[i] <= e_org_s[i];
                sx_r[i]  <= stx_s[i];
                sy_r[i]  <= sty_s[i];
            end
            cx_r        <= clip_xmin_s;
            cy_r        <= clip_ymin_s;
            cxmin_r     <= clip_xmin_s;
            cxmax_r     <= clip_xmax_s;
            cymax_r     <= clip_ymax_s;
            area_neg_r  <= area_neg_s;
            cand_done_r <= 1'b0;
        end else if (state_r == ST_SCAN && advance_s && !cand_done_r) begin
            // Compare against the bounds before stepping so a one-wide or
            // one-high rectangle never wraps.
            if (last_s) begin
                cand_done_r <= 1'b1;
            end else if (row_end_s) begin
                cx_r <= cxmin_r;
                cy_r <= cy_r + COORD_W'(1);
                for (int i = 0; i < 3; i++) begin
                    e_r[i]   <= row_r[i] + sy_r[i];
                    row_r[i] <= row_r[i] + sy_r[i];
                end
            end else begin
                cx_r <= cx_r + COORD_W'(1);
                for (int i = 0; i < 3; i++) begin
                    e_r[i] <= e_r[i] + sx_r[i];
                end
            end
        end
    end

    // Output register: loads on an inside candidate, empties on a handshake,
    // and holds its payload while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_color <= '0;
        end else if (state_r == ST_SCAN && advance_s) begin
            if (!cand_done_r && inside_s) begin
                pixel_valid <= 1'b1;
                pixel_x     <= cx_r;
                pixel_y     <= cy_r;
                pixel_color <= color_r;
            end else begin
                pixel_valid <= 1'b0;
            end
        end
    end

endmodule
